dcache_sa_wt: RTL

//  Parametrised set-associative, write-through, no-write-allocate data cache.

---
 rtl/dcache_sa_wt.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_sa_wt.sv
`default_nettype none
// ============================================================================
// Module      : dcache_sa_wt
// Description : Set-associative, write-through, no-write-allocate data cache
//               between the cv32e40p OBI data port and data memory. One
//               outstanding transaction, FIFO replacement per set, flush and
//               bypass modes, saturating load hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_sa_wt #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cache_en_i,
  input  logic             flush_i,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic [31:0]      data_addr_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic [31:0]      mem_addr_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int c_IDX_W = $clog2(NUM_SETS);
  localparam int c_TAG_W = 32 - c_IDX_W - 2;
  localparam int c_WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_LOOKUP = 2'd1;
  localparam logic [1:0] c_S_MREQ   = 2'd2;
  localparam logic [1:0] c_S_MWAIT  = 2'd3;

  // FSM
  logic [1:0]         r_state;
  logic [1:0]         w_next_state;

  // Captured core request
  logic [31:0]        r_addr;
  logic               r_we;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic               r_en;

  // Cache storage: one 32-bit word per line
  logic [NUM_WAYS-1:0] r_valid    [NUM_SETS];
  logic [c_TAG_W-1:0]  r_tag      [NUM_SETS][NUM_WAYS];
  logic [31:0]         r_data     [NUM_SETS][NUM_WAYS];
  logic [c_WAY_W-1:0]  r_fifo_ptr [NUM_SETS];

  logic [CNT_W-1:0]   r_hit_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;

  // Lookup / replacement wires, all derived from the captured address
  logic [c_IDX_W-1:0] w_idx;
  logic [c_TAG_W-1:0] w_tag;
  logic               w_hit;
  logic [c_WAY_W-1:0] w_hit_way;
  logic [31:0]        w_hit_data;
  logic [c_WAY_W-1:0] w_victim;
  logic               w_gnt;
  logic               w_flush;
  logic               w_fill;
  logic               w_merge;

  assign w_idx = r_addr[c_IDX_W+1:2];
  assign w_tag = r_addr[31:c_IDX_W+2];

  // Grant only when idle; a pending flush takes priority over a new request
  assign w_gnt      = data_req_i & (r_state == c_S_IDLE) & ~flush_i;
  assign w_flush    = flush_i & (r_state == c_S_IDLE);
  assign data_gnt_o = w_gnt;

  // Loads that were looked up (cache enabled at grant) allocate on return
  assign w_fill  = (r_state == c_S_MWAIT) & mem_rvalid_i & ~r_we & r_en;
  // Stores update a resident copy in place regardless of cache mode
  assign w_merge = (r_state == c_S_MWAIT) & mem_rvalid_i & r_we & w_hit;

  assign w_hit_data = r_data[w_idx][w_hit_way];
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

  // Tag compare across all ways of the addressed set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_WAY_W'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the set's FIFO pointer
  always_comb begin
    w_victim = r_fifo_ptr[w_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_victim = c_WAY_W'(w);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_gnt) begin
          w_next_state = (!data_we_i && cache_en_i) ? c_S_LOOKUP : c_S_MREQ;
        end
      end
      c_S_LOOKUP: begin
        w_next_state = w_hit ? c_S_IDLE : c_S_MREQ;
      end
      c_S_MREQ: begin
        if (mem_gnt_i) begin
          w_next_state = c_S_MWAIT;
        end
      end
      c_S_MWAIT: begin
        if (mem_rvalid_i) begin
          w_next_state = c_S_IDLE;
        end
      end
      default: w_next_state = c_S_IDLE;
    endcase
  end

  // Outputs; memory-side outputs depend only on state and captured registers,
  // and everything is held at zero while reset is asserted
  always_comb begin
    data_rvalid_o = 1'b0;
    data_rdata_o  = 32'h0;
    mem_req_o     = 1'b0;
    mem_addr_o    = 32'h0;
    mem_we_o      = 1'b0;
    mem_be_o      = 4'h0;
    mem_wdata_o   = 32'h0;
    busy_o        = 1'b0;
    if (!rst) begin
      busy_o = (r_state != c_S_IDLE);
      case (r_state)
        c_S_LOOKUP: begin
          if (w_hit) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = w_hit_data;
          end
        end
        c_S_MREQ: begin
          mem_req_o   = 1'b1;
          mem_addr_o  = r_addr;
          mem_we_o    = r_we;
          mem_be_o    = r_we ? r_be : 4'hF;
          mem_wdata_o = r_we ? r_wdata : 32'h0;
        end
        c_S_MWAIT: begin
          if (mem_rvalid_i) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = r_we ? 32'h0 : mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Request capture, valid bits, FIFO pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= 32'h0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_en       <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s]    <= '0;
        r_fifo_ptr[s] <= '0;
      end
    end else begin
      if (w_gnt) begin
        r_addr  <= data_addr_i;
        r_we    <= data_we_i;
        r_be    <= data_be_i;
        r_wdata <= data_wdata_i;
        r_en    <= cache_en_i;
      end
      if (w_flush) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          r_valid[s] <= '0;
        end
      end else if (w_fill) begin
        r_valid[w_idx][w_victim] <= 1'b1;
        r_fifo_ptr[w_idx]        <= (NUM_WAYS == 1) ? '0
                                    : r_fifo_ptr[w_idx] + c_WAY_W'(1);
      end
      if (r_state == c_S_LOOKUP) begin
        if (w_hit) begin
          if (r_hit_cnt != {CNT_W{1'b1}}) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
          end
        end else begin
          if (r_miss_cnt != {CNT_W{1'b1}}) begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // Tag and data arrays: line fill on load return, byte merge on store hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_tag[w_idx][w_victim]  <= w_tag;
        r_data[w_idx][w_victim] <= mem_rdata_i;
      end else if (w_merge) begin
        for (int b = 0; b < 4; b++) begin
          if (r_be[b]) begin
            r_data[w_idx][w_hit_way][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
